forward_ctrl: RTL

FORWARD_CTRL -- requirements
Module: forward_ctrl

---
 rtl/forward_ctrl_pkg.sv | 30 +++
 rtl/forward_ctrl_fwd_match.sv | 35 +++
 rtl/forward_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/forward_ctrl_pkg.sv
// Shared types for the operand-forwarding / load-use controller:
// FSM encoding, pipeline-entry record, per-operand select bundle, debug view.
package forward_ctrl_pkg;
  localparam int RA_W_DEF = 5;
  // Entries hold rd zero-extended to this width so any RA_W up to it fits.
  localparam int RA_MAX_W = 8;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fwd_state_e;

  typedef struct packed {
    logic                valid;
    logic [RA_MAX_W-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } pipe_entry_t;

  typedef struct packed {
    logic alu_alu;
    logic bypass;
    logic dmem;
  } fwd_sel_t;

  typedef struct packed {
    fwd_state_e  state;
    pipe_entry_t wb;
  } fwd_dbg_t;
endpackage

// File: rtl/forward_ctrl_fwd_match.sv
// Per-operand hazard matcher: picks the newest producer of one decode source
// register and flags a load-use conflict against the instruction in EX.
module fwd_match
  import forward_ctrl_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] rs,
  input  logic            rs_used,
  input  pipe_entry_t     d1,
  input  pipe_entry_t     d2,
  output fwd_sel_t        sel,
  output logic            load_use
);
  logic rs_live;
  logic hit1;
  logic hit2;

  // r0 is hardwired zero, so it is never forwarded.
  assign rs_live  = rs_used && (rs != '0);
  assign hit1     = rs_live && d1.valid && d1.reg_write && (d1.rd == RA_MAX_W'(rs));
  assign hit2     = rs_live && d2.valid && d2.reg_write && (d2.rd == RA_MAX_W'(rs));
  assign load_use = hit1 && d1.mem_read;

  always_comb begin
    sel = '0;
    if (hit1 && !d1.mem_read) begin
      sel.alu_alu = 1'b1;
    end else if (hit2 && d2.mem_read) begin
      sel.dmem = 1'b1;
    end else if (hit2) begin
      sel.bypass = 1'b1;
    end
  end
endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use stall controller: tracks EX/MEM/WB destinations,
// registers EX operand selects, and inserts one bubble on a load-use hazard.
module forward_ctrl
  import forward_ctrl_pkg::*;
#(
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             alu_alu_s1,
  output logic             bypass_alu1,
  output logic             dmem_alu1,
  output logic             alu_alu_s2,
  output logic             bypass_alu2,
  output logic             dmem_alu2,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  output fwd_dbg_t         dbg
);
  pipe_entry_t d1, d2, d3;
  pipe_entry_t id_entry;
  fwd_sel_t    sel1_c, sel2_c, sel1_q, sel2_q;
  logic        lu1, lu2;
  logic        advance;
  fwd_state_e  state_q, state_d;

  fwd_match #(.RA_W(RA_W)) u_match1 (
    .rs(id_rs1), .rs_used(id_use1), .d1(d1), .d2(d2), .sel(sel1_c), .load_use(lu1)
  );
  fwd_match #(.RA_W(RA_W)) u_match2 (
    .rs(id_rs2), .rs_used(id_use2), .d1(d1), .d2(d2), .sel(sel2_c), .load_use(lu2)
  );

  // A stall only starts from RUN; the stall bubble guarantees d1 is empty in STALL.
  assign stall   = (state_q == RUN) && id_valid && (lu1 || lu2) && !flush;
  assign advance = id_valid && !stall && !flush;

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = advance;
    id_entry.rd        = RA_MAX_W'(id_rd);
    id_entry.reg_write = id_reg_write;
    id_entry.mem_read  = id_mem_read;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (stall) state_d = STALL;
      STALL:   state_d = RUN;
      default: state_d = RUN;
    endcase
    if (flush) state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      sel1_q    <= '0;
      sel2_q    <= '0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      d1      <= id_entry;
      d2      <= d1;
      d3      <= d2;
      // Selects belong to the instruction entering EX; bubbles carry none.
      sel1_q  <= advance ? sel1_c : '0;
      sel2_q  <= advance ? sel2_c : '0;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign alu_alu_s1  = sel1_q.alu_alu;
  assign bypass_alu1 = sel1_q.bypass;
  assign dmem_alu1   = sel1_q.dmem;
  assign alu_alu_s2  = sel2_q.alu_alu;
  assign bypass_alu2 = sel2_q.bypass;
  assign dmem_alu2   = sel2_q.dmem;
  assign dbg.state   = state_q;
  assign dbg.wb      = d3;
endmodule
